// File: rtl/spi_master_if.sv
// SPIbus: shared SPI bus between one master and NSLAVES slaves.
//   sck  - serial clock, driven by the master (idle low)
//   mosi - master-out data, driven by the master
//   miso - slave-out data, driven by the selected slave
//   ss   - per-slave select lines, active high, driven by the master
interface SPIbus #(
  parameter int NSLAVES = 4
);
  logic               sck;
  logic               mosi;
  logic               miso;
  logic [NSLAVES-1:0] ss;

  modport Master (output sck, output mosi, output ss, input miso);
  modport Slave  (input sck, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_master.sv
// spi_master: single-byte, full-duplex SPI master (CPOL=0, CPHA=0).
// A Start_i accepted in IDLE latches TxData_i and SlvSel_i, asserts the
// selected ss line, clocks out 8 bits MSB-first on MOSI and captures 8 bits
// from MISO, then deasserts ss and presents the received byte with a
// one-cycle Done_o pulse. Setup/hold/gap windows keep a synchronizing slave
// happy (2-flop input sync plus a transmit-load step after select).
//
// Ports:
//   Clk_i    - system clock, rising edge
//   Rst_i    - synchronous active-high reset
//   Spim     - SPIbus master modport (sck, mosi, ss out; miso in)
//   Start_i  - transfer request, honoured only while Busy_o=0
//   SlvSel_i - target slave index, latched on accept
//   TxData_i - byte to send, latched on accept
//   Busy_o   - high from the cycle after accept until back in IDLE
//   Done_o   - one-cycle pulse when RxData_o updates
//   RxData_o - last received byte
module spi_master #(
  parameter  int NSLAVES     = 4,
  parameter  int HALF_PERIOD = 4,
  parameter  int SS_SETUP    = 8,
  parameter  int SS_HOLD     = 4,
  parameter  int SS_GAP      = 4,
  localparam int SW          = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
  input  logic          Clk_i,
  input  logic          Rst_i,
  SPIbus.Master         Spim,
  input  logic          Start_i,
  input  logic [SW-1:0] SlvSel_i,
  input  logic [7:0]    TxData_i,
  output logic          Busy_o,
  output logic          Done_o,
  output logic [7:0]    RxData_o
);

  // Phase counter must hold the longest phase length minus one.
  localparam int M1   = (SS_SETUP > HALF_PERIOD) ? SS_SETUP : HALF_PERIOD;
  localparam int M2   = (SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP;
  localparam int MAXD = (M1 > M2) ? M1 : M2;
  localparam int CW   = (MAXD > 2) ? $clog2(MAXD) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_tx;
  logic [7:0]      r_rx;
  logic [7:0]      r_rxdata;
  logic [SW-1:0]   r_sel;
  logic            r_done;
  logic            r_miso_s1;
  logic            r_miso_s2;

  logic                w_end;
  logic                w_miso;
  logic                w_sel_ok;
  logic [NSLAVES-1:0]  w_ss_dec;
  logic                w_sck;
  logic                w_mosi;
  logic [NSLAVES-1:0]  w_ss;
  logic                w_busy;

  // Counter reload value for a phase: its length minus one. Every phase is
  // a distinct state, so a state change is exactly a phase entry.
  function automatic logic [CW-1:0] f_len(input state_t s);
    case (s)
      SETUP:     return CW'(SS_SETUP - 1);
      HIGH, LOW: return CW'(HALF_PERIOD - 1);
      HOLD:      return CW'(SS_HOLD - 1);
      GAP:       return CW'(SS_GAP - 1);
      default:   return '0;
    endcase
  endfunction

  assign w_end = (r_cnt == '0);

  // One-hot select decode; an out-of-range index decodes to no line at all.
  always_comb begin
    w_ss_dec = '0;
    for (int i = 0; i < NSLAVES; i++)
      if (r_sel == SW'(i)) w_ss_dec[i] = 1'b1;
  end

  // With no valid slave selected, MISO is floating; force every sample to 0.
  assign w_sel_ok = |w_ss_dec;
  assign w_miso   = w_sel_ok & r_miso_s2;

  // ---- state register + datapath -------------------------------------
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rxdata  <= '0;
      r_sel     <= '0;
      r_done    <= 1'b0;
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_miso_s1 <= Spim.miso;
      r_miso_s2 <= r_miso_s1;
      r_done    <= 1'b0;

      if (w_next != r_state)  r_cnt <= f_len(w_next);
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;

      case (r_state)
        IDLE: if (Start_i) begin
          r_tx  <= TxData_i;
          r_sel <= SlvSel_i;
          r_bit <= '0;
          r_rx  <= '0;
        end
        // Last cycle before each SCK rise: capture the bit the slave holds.
        SETUP, LOW: if (w_end) r_rx <= {r_rx[6:0], w_miso};
        // Advance MOSI only as SCK falls, so it is stable across the rise.
        HIGH: if (w_end && r_bit != 3'd7) begin
          r_bit <= r_bit + 3'd1;
          r_tx  <= {r_tx[6:0], 1'b0};
        end
        // Result and Done land together on the first GAP cycle.
        HOLD: if (w_end) begin
          r_rxdata <= r_rx;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---- next-state logic -----------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (Start_i) w_next = SETUP;
      SETUP: if (w_end)   w_next = HIGH;
      HIGH:  if (w_end)   w_next = (r_bit == 3'd7) ? HOLD : LOW;
      LOW:   if (w_end)   w_next = HIGH;
      HOLD:  if (w_end)   w_next = GAP;
      GAP:   if (w_end)   w_next = IDLE;
      default:            w_next = IDLE;
    endcase
  end

  // ---- outputs ----------------------------------------------------------
  always_comb begin
    w_sck  = 1'b0;
    w_mosi = 1'b0;
    w_ss   = '0;
    w_busy = (r_state != IDLE);
    case (r_state)
      SETUP, HIGH, LOW, HOLD: begin
        w_ss   = w_ss_dec;
        w_mosi = r_tx[7];
        w_sck  = (r_state == HIGH);
      end
      default: ;
    endcase
  end

  assign Spim.sck  = w_sck;
  assign Spim.mosi = w_mosi;
  assign Spim.ss   = w_ss;
  assign Busy_o    = w_busy;
  assign Done_o    = r_done;
  assign RxData_o  = r_rxdata;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (default timing with 4 slaves, and
// NSLAVES=3 / HALF_PERIOD=8 / SS_SETUP=12). A behavioural slave per bus loads
// a byte when its select rises, shifts MISO on SCK falls and captures MOSI on
// SCK rises. With no select asserted the bus MISO idles high.
module tb_spi_master;
  localparam int HP0 = 4, SU0 = 8, HO = 4, GP = 4;
  localparam int HP1 = 8, SU1 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      start;
  logic [1:0][1:0] sel;
  logic [1:0][7:0] tx;
  logic [1:0]      busy_w, done_w;
  logic [1:0][7:0] rx_w;

  SPIbus #(.NSLAVES(4)) bus0 ();
  SPIbus #(.NSLAVES(3)) bus1 ();

  spi_master d0 (
    .Clk_i(clk), .Rst_i(rst), .Spim(bus0), .Start_i(start[0]),
    .SlvSel_i(sel[0]), .TxData_i(tx[0]), .Busy_o(busy_w[0]),
    .Done_o(done_w[0]), .RxData_o(rx_w[0]));

  spi_master #(.NSLAVES(3), .HALF_PERIOD(HP1), .SS_SETUP(SU1)) d1 (
    .Clk_i(clk), .Rst_i(rst), .Spim(bus1), .Start_i(start[1]),
    .SlvSel_i(sel[1]), .TxData_i(tx[1]), .Busy_o(busy_w[1]),
    .Done_o(done_w[1]), .RxData_o(rx_w[1]));

  logic [1:0]      sck_w, mosi_w;
  logic [1:0][3:0] ss_w;
  logic [1:0][7:0] sh;
  assign sck_w  = {bus1.sck, bus0.sck};
  assign mosi_w = {bus1.mosi, bus0.mosi};
  assign ss_w[0] = bus0.ss;
  assign ss_w[1] = {1'b0, bus1.ss};
  assign bus0.miso = (|ss_w[0]) ? sh[0][7] : 1'b1;
  assign bus1.miso = (|ss_w[1]) ? sh[1][7] : 1'b1;

  // Monitor / slave model state
  logic [7:0] slv_byte [2][4];
  int rises_tot[2], dones_tot[2], acc_cnt[2], acc_cyc[2], done_cyc[2];
  int rise0[2], rise1[2], rlast[2], xrises[2], fall_cyc[2], gap_len[2], mviol[2];
  logic [3:0] xss[2], pss[2];
  logic       psck[2], pmosi[2], done_busy[2];
  logic [7:0] srx[2], slv_got[2];

  function automatic int oh(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (start[d] && !busy_w[d] && !rst) begin
        acc_cyc[d] <= cyc;
        acc_cnt[d] <= acc_cnt[d] + 1;
        xss[d]     <= '0;
        xrises[d]  <= 0;
      end else begin
        xss[d] <= xss[d] | ss_w[d];
        if (sck_w[d] && !psck[d]) begin
          xrises[d] <= xrises[d] + 1;
          if (xrises[d] == 0) rise0[d] <= cyc;
          if (xrises[d] == 1) rise1[d] <= cyc;
        end
      end
      if (sck_w[d] && !psck[d]) begin
        rises_tot[d] <= rises_tot[d] + 1;
        rlast[d]     <= cyc;
        srx[d]       <= {srx[d][6:0], mosi_w[d]};
      end
      if (!sck_w[d] && psck[d]) sh[d] <= {sh[d][6:0], 1'b0};
      if (ss_w[d] != 4'd0 && pss[d] == 4'd0) begin
        sh[d]      <= slv_byte[d][oh(ss_w[d])];
        srx[d]     <= 8'h00;
        gap_len[d] <= cyc - fall_cyc[d];
      end
      if (ss_w[d] == 4'd0 && pss[d] != 4'd0) begin
        slv_got[d]  <= srx[d];
        fall_cyc[d] <= cyc;
      end
      if (done_w[d]) begin
        dones_tot[d] <= dones_tot[d] + 1;
        done_cyc[d]  <= cyc;
        done_busy[d] <= busy_w[d];
      end
      if (sck_w[d] && (mosi_w[d] !== pmosi[d])) mviol[d] <= mviol[d] + 1;
      psck[d]  <= sck_w[d];
      pss[d]   <= ss_w[d];
      pmosi[d] <= mosi_w[d];
    end
  end

  int checks = 0;
  int errors = 0;
  int b_dones, b_rises, b_acc;
  int rs;
  logic [7:0] rt, rb, b1, b2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int n = 0;
    while (dones_tot[d] < target && n < budget) begin @(negedge clk); n++; end
    chk($sformatf("d%0d_done_wait", d), 32'(dones_tot[d] >= target), 32'd1);
  endtask

  task automatic wait_acc(input int d, input int target, input int budget);
    int n = 0;
    while (acc_cnt[d] < target && n < budget) begin @(negedge clk); n++; end
    chk($sformatf("d%0d_acc_wait", d), 32'(acc_cnt[d] >= target), 32'd1);
  endtask

  task automatic begin_xfer(input int d, input int s, input logic [7:0] t, input logic [7:0] b);
    slv_byte[d][s] = b;
    b_dones = dones_tot[d];
    b_rises = rises_tot[d];
    b_acc   = acc_cnt[d];
    @(negedge clk);
    start[d] = 1'b1; sel[d] = 2'(s); tx[d] = t;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Reference: the slave sees t; RxData is the slave's byte when the index
  // names a real slave, otherwise 0; timing follows the phase lengths.
  task automatic finish_check(input int d, input int s, input logic [7:0] t, input logic [7:0] b);
    int hp  = (d == 0) ? HP0 : HP1;
    int su  = (d == 0) ? SU0 : SU1;
    int ns  = (d == 0) ? 4 : 3;
    int lat = 1 + su + 15 * hp + HO;
    logic [7:0] er = (s < ns) ? b : 8'h00;
    logic [3:0] es = (s < ns) ? 4'(1 << s) : 4'h0;
    wait_done(d, b_dones + 1, 600);
    chk($sformatf("d%0d_rxdata", d), 32'(rx_w[d]), 32'(er));
    chk($sformatf("d%0d_done_latency", d), 32'(done_cyc[d] - acc_cyc[d]), 32'(lat));
    chk($sformatf("d%0d_first_rise", d), 32'(rise0[d] - acc_cyc[d]), 32'(1 + su));
    chk($sformatf("d%0d_rise_spacing", d), 32'(rise1[d] - rise0[d]), 32'(2 * hp));
    chk($sformatf("d%0d_rise_span", d), 32'(rlast[d] - rise0[d]), 32'(14 * hp));
    chk($sformatf("d%0d_sck_rises", d), 32'(xrises[d]), 32'd8);
    chk($sformatf("d%0d_ss_seen", d), 32'(xss[d]), 32'(es));
    chk($sformatf("d%0d_busy_at_done", d), 32'(done_busy[d]), 32'd1);
    if (s < ns) chk($sformatf("d%0d_slave_rx", d), 32'(slv_got[d]), 32'(t));
    repeat (GP + 2) @(negedge clk);
    chk($sformatf("d%0d_idle_after", d), 32'(busy_w[d]), 32'd0);
    chk($sformatf("d%0d_done_count", d), 32'(dones_tot[d] - b_dones), 32'd1);
    chk($sformatf("d%0d_acc_count", d), 32'(acc_cnt[d] - b_acc), 32'd1);
  endtask

  initial begin
    start = '0; sel = '0; tx = '0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) slv_byte[d][i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("rst_done%0d", d), 32'(done_w[d]), 32'd0);
      chk($sformatf("rst_rx%0d", d), 32'(rx_w[d]), 32'd0);
      chk($sformatf("rst_sck%0d", d), 32'(sck_w[d]), 32'd0);
      chk($sformatf("rst_mosi%0d", d), 32'(mosi_w[d]), 32'd0);
      chk($sformatf("rst_ss%0d", d), 32'(ss_w[d]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic transfer: slave 1, A5 out, 3C back
    begin_xfer(0, 1, 8'hA5, 8'h3C);
    finish_check(0, 1, 8'hA5, 8'h3C);

    // Back-to-back with Start_i held high
    b1 = 8'($urandom) | 8'h01;
    b2 = 8'($urandom) | 8'h01;
    slv_byte[0][2] = b1;
    b_dones = dones_tot[0]; b_rises = rises_tot[0]; b_acc = acc_cnt[0];
    @(negedge clk);
    start[0] = 1'b1; sel[0] = 2'd2; tx[0] = 8'h00;
    wait_acc(0, b_acc + 1, 10);
    repeat (3) @(negedge clk);
    tx[0] = 8'hFF; slv_byte[0][2] = b2;
    wait_done(0, b_dones + 1, 200);
    chk("b2b_rx1", 32'(rx_w[0]), 32'(b1));
    chk("b2b_slave1", 32'(slv_got[0]), 32'h00);
    wait_acc(0, b_acc + 2, 20);
    start[0] = 1'b0;
    wait_done(0, b_dones + 2, 200);
    chk("b2b_rx2", 32'(rx_w[0]), 32'(b2));
    chk("b2b_slave2", 32'(slv_got[0]), 32'hFF);
    // ss low for the GAP phase plus the IDLE cycle in which the restart is accepted
    chk("b2b_ss_gap", 32'(gap_len[0]), 32'(GP + 1));
    chk("b2b_rises", 32'(rises_tot[0] - b_rises), 32'd16);
    repeat (GP + 2) @(negedge clk);
    chk("b2b_acc", 32'(acc_cnt[0] - b_acc), 32'd2);
    chk("b2b_dones", 32'(dones_tot[0] - b_dones), 32'd2);

    // Start pulsed while busy is ignored, not queued
    rt = 8'($urandom); rb = 8'($urandom) | 8'h01;
    begin_xfer(0, 0, rt, rb);
    repeat (20) @(negedge clk);
    start[0] = 1'b1; sel[0] = 2'd3; tx[0] = ~rt;
    @(negedge clk);
    start[0] = 1'b0;
    finish_check(0, 0, rt, rb);
    repeat (100) @(negedge clk);
    chk("ign_dones", 32'(dones_tot[0] - b_dones), 32'd1);
    chk("ign_rises", 32'(rises_tot[0] - b_rises), 32'd8);

    // Reset during the 4th HIGH phase
    begin_xfer(0, 3, 8'h5A, 8'hC3);
    begin
      int n = 0;
      while (xrises[0] < 4 && n < 200) begin @(negedge clk); n++; end
    end
    chk("mid_rst_reached", 32'(xrises[0]), 32'd4);
    chk("mid_rst_sck_high", 32'(sck_w[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sck", 32'(sck_w[0]), 32'd0);
    chk("mid_rst_ss", 32'(ss_w[0]), 32'd0);
    chk("mid_rst_mosi", 32'(mosi_w[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_rx", 32'(rx_w[0]), 32'd0);
    chk("mid_rst_done", 32'(done_w[0]), 32'd0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_rst_no_done", 32'(dones_tot[0] - b_dones), 32'd0);
    begin_xfer(0, 3, 8'h96, 8'h69);
    finish_check(0, 3, 8'h96, 8'h69);

    // Randomized transfers on the default instance
    for (int k = 0; k < 4; k++) begin
      rs = int'($urandom_range(3, 0));
      rt = 8'($urandom);
      rb = 8'($urandom);
      begin_xfer(0, rs, rt, rb);
      finish_check(0, rs, rt, rb);
    end

    // Slow instance: highest valid index, then an out-of-range index
    rt = 8'($urandom); rb = 8'($urandom) | 8'h01;
    begin_xfer(1, 2, rt, rb);
    finish_check(1, 2, rt, rb);
    rt = 8'($urandom); rb = 8'($urandom) | 8'h01;
    begin_xfer(1, 3, rt, rb);
    finish_check(1, 3, rt, rb);

    chk("mosi_stable0", 32'(mviol[0]), 32'd0);
    chk("mosi_stable1", 32'(mviol[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
